// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM request/response FIFO pair among several requesters.
// A small tag FIFO remembers who issued each request so in-order responses return to the right port.
module sdram_port_arbiter #(
   parameter int NUM_PORTS       = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int WORD_W          = 41
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_PORTS-1:0]              req_valid,
   input  logic [NUM_PORTS*WORD_W-1:0]       req_data,
   output logic [NUM_PORTS-1:0]              req_ready,
   output logic [NUM_PORTS-1:0]              resp_valid,
   output logic [15:0]                       resp_data,
   input  logic [NUM_PORTS-1:0]              resp_ready,
   output logic [WORD_W-1:0]                 req_fifo_data,
   output logic                              req_fifo_write,
   input  logic                              req_fifo_full,
   input  logic [WORD_W-1:0]                 resp_fifo_data,
   output logic                              resp_fifo_read,
   input  logic                              resp_fifo_empty,
   output logic [$clog2(MAX_OUTSTANDING):0]  outstanding
);

   localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W  = PTR_W + 1;
   localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   // Handshake: a transfer happens on the clock edge where valid and ready are both high;
   // ready never depends on anything the same port could change in response to ready.

   logic [PORT_W-1:0] last;
   logic [PORT_W-1:0] grant_idx;
   logic [PORT_W-1:0] cand;
   logic [PORT_W-1:0] head;
   logic [PORT_W-1:0] tag_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              grant_found;
   logic              issue_ok;
   logic              tag_nonempty;
   logic              push;
   logic              pop;

   // The !req_fifo_write term covers the FIFO full flag lagging a registered write by one cycle.
   assign issue_ok     = !req_fifo_full && !req_fifo_write &&
                         (outstanding < CNT_W'(MAX_OUTSTANDING));
   assign tag_nonempty = (outstanding != '0);
   assign head         = tag_mem[rd_ptr];

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand = PORT_W'((int'(last) + i) % NUM_PORTS);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
      req_ready = '0;
      if (issue_ok && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      resp_valid = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         resp_valid[p] = !resp_fifo_empty && tag_nonempty && (head == PORT_W'(p));
      end
   end

   assign resp_data      = resp_fifo_data[15:0];
   assign resp_fifo_read = |(resp_valid & resp_ready);
   assign push           = |req_ready;
   assign pop            = resp_fifo_read;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_fifo_write <= 1'b0;
         req_fifo_data  <= '0;
         last           <= PORT_W'(NUM_PORTS - 1);
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         outstanding    <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            tag_mem[i] <= '0;
         end
      end else begin
         req_fifo_write <= push;
         if (push) begin
            req_fifo_data   <= req_data[grant_idx*WORD_W +: WORD_W];
            tag_mem[wr_ptr] <= grant_idx;
            wr_ptr          <= wr_ptr + 1'b1;
            last            <= grant_idx;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: cycle table from reset, then multi-cycle sequences against
// a small latency-based SDRAM stand-in that answers every request in order.
module tb_sdram_port_arbiter;

   localparam int W = 41;
   localparam logic [2:0] MAXO = 3'd4;
   localparam logic [W-1:0] TW0 = {1'b1, 24'h00AA01, 16'h1357};
   localparam logic [W-1:0] TW1 = {1'b0, 24'h00BB02, 16'h0000};

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [1:0]     req_valid = '0;
   logic [2*W-1:0] req_data = '0;
   logic [1:0]     req_ready;
   logic [1:0]     resp_valid;
   logic [15:0]    resp_data;
   logic [1:0]     resp_ready = '0;
   logic [W-1:0]   req_fifo_data;
   logic           req_fifo_write;
   logic           req_fifo_full = 1'b0;
   logic [W-1:0]   resp_fifo_data;
   logic           resp_fifo_read;
   logic           resp_fifo_empty;
   logic [2:0]     outstanding;

   logic           model_en = 1'b0;
   logic           t_empty = 1'b1;
   logic [W-1:0]   t_rdata = '0;
   logic           m_empty = 1'b1;
   logic [W-1:0]   m_data = '0;
   int             lat = 20;
   int             cyc = 0;

   int tests = 0;
   int failed = 0;

   assign resp_fifo_empty = model_en ? m_empty : t_empty;
   assign resp_fifo_data  = model_en ? m_data  : t_rdata;

   sdram_port_arbiter #(.NUM_PORTS(2), .MAX_OUTSTANDING(4), .WORD_W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
      .req_fifo_data(req_fifo_data), .req_fifo_write(req_fifo_write), .req_fifo_full(req_fifo_full),
      .resp_fifo_data(resp_fifo_data), .resp_fifo_read(resp_fifo_read),
      .resp_fifo_empty(resp_fifo_empty), .outstanding(outstanding)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- SDRAM stand-in: fixed latency, in-order answers ----------------
   logic [W-1:0] rq [$];
   int           dq [$];
   logic [15:0]  mem [int];
   int           mk;
   logic [15:0]  mrd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq.delete();
         dq.delete();
         mem.delete();
         m_empty <= 1'b1;
         m_data  <= '0;
      end else begin
         if (model_en && resp_fifo_read && rq.size() != 0) begin
            void'(rq.pop_front());
            void'(dq.pop_front());
         end
         if (model_en && req_fifo_write) begin
            mk = int'(req_fifo_data[39:16]);
            if (req_fifo_data[40]) begin
               mem[mk] = req_fifo_data[15:0];
               mrd = 16'h0000;
            end else begin
               // unwritten locations read back as their low address bits
               mrd = mem.exists(mk) ? mem[mk] : req_fifo_data[31:16];
            end
            rq.push_back({req_fifo_data[40:16], mrd});
            dq.push_back(cyc + lat);
         end
         m_empty <= !(rq.size() != 0 && dq[0] <= cyc + 1);
         m_data  <= (rq.size() != 0) ? rq[0] : '0;
      end
   end

   // ---------------- monitor (samples mid-cycle) ----------------
   int            w_cyc_q [$];
   logic [W-1:0]  w_dat_q [$];
   int            grant_q [$];
   logic [15:0]   r0_q [$];
   logic [15:0]   r1_q [$];
   int            viol_consec, viol_max, viol_full, resume_ok, resume_bad;
   logic          prev_wr, prev_rd, rv1_seen;
   logic [2:0]    prev_out, max_out;

   always begin
      @(negedge clk);
      #3;
      if (req_fifo_write) begin
         if (prev_wr) viol_consec++;
         w_cyc_q.push_back(cyc);
         w_dat_q.push_back(req_fifo_data);
      end
      prev_wr = req_fifo_write;
      if (req_ready != 2'b00) grant_q.push_back(req_ready[1] ? 1 : 0);
      if (outstanding == MAXO && req_ready != 2'b00) viol_max++;
      if (req_fifo_full && req_ready != 2'b00) viol_full++;
      if (outstanding > max_out) max_out = outstanding;
      if (prev_rd && prev_out == MAXO && req_valid != 2'b00 && !req_fifo_full) begin
         if (req_ready != 2'b00) resume_ok++;
         else resume_bad++;
      end
      prev_rd  = resp_fifo_read;
      prev_out = outstanding;
      if (resp_valid[1]) rv1_seen = 1'b1;
      if (resp_valid[0] && resp_ready[0]) r0_q.push_back(resp_data);
      if (resp_valid[1] && resp_ready[1]) r1_q.push_back(resp_data);
   end

   // ---------------- helpers ----------------
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      w_cyc_q.delete(); w_dat_q.delete(); grant_q.delete(); r0_q.delete(); r1_q.delete();
      viol_consec = 0; viol_max = 0; viol_full = 0; resume_ok = 0; resume_bad = 0;
      prev_wr = 1'b0; prev_rd = 1'b0; rv1_seen = 1'b0; prev_out = '0; max_out = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0; resp_ready = '0; req_fifo_full = 1'b0;
      t_empty = 1'b1; t_rdata = '0; req_data = '0;
      repeat (2) next_cycle();
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic issue(input int p, input logic [W-1:0] w);
      logic ok;
      ok = 1'b0;
      req_data[p*W +: W] = w;
      req_valid = '0;
      req_valid[p] = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         #1;
         if (req_ready[p]) ok = 1'b1;
         next_cycle();
      end
      req_valid = '0;
      check($sformatf("issue_p%0d_handshake", p), 64'(ok), 64'(1));
   endtask

   // ---------------- cycle table ----------------
   typedef struct packed {
      logic [1:0] rv;
      logic       full;
      logic       empty;
      logic [1:0] rr;
      logic [1:0] e_rdy;
      logic [1:0] e_rval;
      logic       e_read;
      logic       e_wr;
      logic [1:0] e_wsel;
      logic [2:0] e_out;
   } vec_t;

   vec_t         vecs [16];
   logic [15:0]  exp_q [$];
   logic [15:0]  ed;
   logic         seen;
   int           bad;

   initial begin
      //             rv    full  empty rr     rdy    rval   rd    wr    wsel  out
      vecs[0]  = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0};
      vecs[1]  = '{2'b11, 1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0};
      vecs[2]  = '{2'b11, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'd1, 3'd1};
      vecs[3]  = '{2'b11, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 2'd0, 3'd1};
      vecs[4]  = '{2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 2'd2, 3'd2};
      vecs[5]  = '{2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 2'd0, 3'd2};
      vecs[6]  = '{2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0, 2'd0, 3'd1};
      vecs[7]  = '{2'b01, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 1'b1, 1'b0, 2'd0, 3'd1};
      vecs[8]  = '{2'b11, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 2'd1, 3'd1};
      vecs[9]  = '{2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 2'd0, 3'd1};
      vecs[10] = '{2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1, 2'd2, 3'd2};
      vecs[11] = '{2'b00, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 2'd0, 3'd1};
      vecs[12] = '{2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0};
      vecs[13] = '{2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0};
      vecs[14] = '{2'b10, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0};
      vecs[15] = '{2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'd2, 3'd1};

      // ---- reset state ----
      model_en = 1'b0;
      do_reset();
      #1;
      check("rst_outstanding", 64'(outstanding), 64'(0));
      check("rst_fifo_write", 64'(req_fifo_write), 64'(0));
      check("rst_fifo_data", 64'(req_fifo_data), 64'(0));
      check("rst_resp_valid", 64'(resp_valid), 64'(0));
      check("rst_resp_read", 64'(resp_fifo_read), 64'(0));

      // ---- table: arbitration, routing, push/pop bookkeeping ----
      req_data = {TW1, TW0};
      for (int i = 0; i < 16; i++) begin
         req_valid     = vecs[i].rv;
         req_fifo_full = vecs[i].full;
         t_empty       = vecs[i].empty;
         resp_ready    = vecs[i].rr;
         t_rdata       = {1'b0, 24'hABCDEF, 16'h1000 + 16'(i)};
         #1;
         check($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].e_rdy));
         check($sformatf("v%0d_resp_valid", i), 64'(resp_valid), 64'(vecs[i].e_rval));
         check($sformatf("v%0d_resp_read", i), 64'(resp_fifo_read), 64'(vecs[i].e_read));
         check($sformatf("v%0d_fifo_write", i), 64'(req_fifo_write), 64'(vecs[i].e_wr));
         check($sformatf("v%0d_outstanding", i), 64'(outstanding), 64'(vecs[i].e_out));
         check($sformatf("v%0d_resp_data", i), 64'(resp_data), 64'(16'h1000 + 16'(i)));
         if (vecs[i].e_wr)
            check($sformatf("v%0d_fifo_data", i), 64'(req_fifo_data),
                  64'((vecs[i].e_wsel == 2'd1) ? TW0 : TW1));
         next_cycle();
      end

      // ---- single port write then read ----
      model_en = 1'b1;
      do_reset();
      resp_ready = 2'b01;
      issue(0, {1'b1, 24'h000010, 16'hBEEF});
      issue(0, {1'b0, 24'h000010, 16'h0000});
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         next_cycle();
         seen = (r0_q.size() >= 2);
      end
      check("single_resp_count", 64'(r0_q.size()), 64'(2));
      check("single_read_data", 64'(r0_q[1]), 64'(16'hBEEF));
      check("single_no_p1_valid", 64'(rv1_seen), 64'(0));
      check("single_write_count", 64'(w_dat_q.size()), 64'(2));
      check("single_word0", 64'(w_dat_q[0]), 64'({1'b1, 24'h000010, 16'hBEEF}));
      check("single_word1", 64'(w_dat_q[1]), 64'({1'b0, 24'h000010, 16'h0000}));
      check("single_write_spacing", 64'(w_cyc_q[1] - w_cyc_q[0]), 64'(2));

      // ---- round robin under continuous requests, saturation at MAX_OUTSTANDING ----
      do_reset();
      resp_ready = 2'b11;
      req_data   = {{1'b0, 24'h000100, 16'h0000}, {1'b1, 24'h000100, 16'h1234}};
      req_valid  = 2'b11;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         next_cycle();
         #1;
         seen = (grant_q.size() >= 8);
      end
      req_valid = 2'b00;
      check("rr_eight_grants", 64'(seen), 64'(1));
      for (int i = 0; i < 8; i++)
         check($sformatf("rr_grant%0d", i), 64'(grant_q[i]), 64'(i % 2));
      check("rr_no_back_to_back_write", 64'(viol_consec), 64'(0));
      check("sat_max_outstanding", 64'(max_out), 64'(MAXO));
      check("sat_no_ready_at_max", 64'(viol_max), 64'(0));
      check("sat_resume_seen", 64'(resume_ok > 0), 64'(1));
      check("sat_resume_late", 64'(resume_bad), 64'(0));
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         next_cycle();
         seen = (r0_q.size() + r1_q.size() >= grant_q.size()) && (outstanding == 3'd0);
      end
      check("rr_drained", 64'(seen), 64'(1));
      check("rr_p0_resps", 64'(r0_q.size()), 64'(4));
      check("rr_p1_resps", 64'(r1_q.size()), 64'(4));
      bad = 0;
      foreach (r1_q[i]) if (r1_q[i] !== 16'h1234) bad++;
      check("rr_p1_read_data", 64'(bad), 64'(0));

      // ---- full held for 10 cycles ----
      do_reset();
      resp_ready    = 2'b11;
      req_fifo_full = 1'b1;
      req_data[0 +: W] = {1'b1, 24'h000200, 16'h5555};
      req_valid = 2'b01;
      for (int i = 0; i < 10; i++) begin
         #1;
         check($sformatf("full_c%0d_ready", i), 64'(req_ready), 64'(0));
         check($sformatf("full_c%0d_write", i), 64'(req_fifo_write), 64'(0));
         next_cycle();
      end
      req_fifo_full = 1'b0;
      #1;
      check("full_drop_ready", 64'(req_ready), 64'(2'b01));
      next_cycle();
      req_valid = 2'b00;
      check("full_drop_write", 64'(req_fifo_write), 64'(1));
      check("full_drop_data", 64'(req_fifo_data), 64'({1'b1, 24'h000200, 16'h5555}));
      check("full_no_ready_while_full", 64'(viol_full), 64'(0));

      // ---- interleaved tags with head-of-line blocking on port 1 ----
      do_reset();
      resp_ready = 2'b01;
      exp_q.delete();
      issue(0, {1'b0, 24'h000011, 16'h0000}); exp_q.push_back(16'h0011);
      issue(1, {1'b0, 24'h000022, 16'h0000}); exp_q.push_back(16'h0022);
      issue(0, {1'b0, 24'h000033, 16'h0000}); exp_q.push_back(16'h0033);
      seen = 1'b0;
      for (int i = 0; i < 80 && !seen; i++) begin
         next_cycle(); #1;
         seen = resp_valid[0];
      end
      check("il_first_p0", 64'(seen), 64'(1));
      ed = exp_q.pop_front();
      check("il_first_data", 64'(resp_data), 64'(ed));
      check("il_first_read", 64'(resp_fifo_read), 64'(1));
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         next_cycle(); #1;
         seen = resp_valid[1];
      end
      check("il_second_p1", 64'(seen), 64'(1));
      for (int k = 0; k < 5; k++) begin
         check($sformatf("il_hold%0d_valid", k), 64'(resp_valid), 64'(2'b10));
         check($sformatf("il_hold%0d_read", k), 64'(resp_fifo_read), 64'(0));
         next_cycle(); #1;
      end
      resp_ready = 2'b11;
      #1;
      ed = exp_q.pop_front();
      check("il_second_read", 64'(resp_fifo_read), 64'(1));
      check("il_second_data", 64'(resp_data), 64'(ed));
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         next_cycle(); #1;
         seen = resp_valid[0];
      end
      check("il_third_p0", 64'(seen), 64'(1));
      ed = exp_q.pop_front();
      check("il_third_data", 64'(resp_data), 64'(ed));
      check("il_third_read", 64'(resp_fifo_read), 64'(1));
      check("il_queue_empty", 64'(exp_q.size()), 64'(0));

      // ---- asynchronous reset with three requests outstanding ----
      do_reset();
      resp_ready = 2'b00;
      issue(0, {1'b0, 24'h000041, 16'h0000});
      issue(1, {1'b0, 24'h000042, 16'h0000});
      issue(0, {1'b0, 24'h000043, 16'h0000});
      #1;
      check("arst_pre_outstanding", 64'(outstanding), 64'(3));
      check("arst_pre_write", 64'(req_fifo_write), 64'(1));
      rst_n = 1'b0;
      #1;
      check("arst_outstanding", 64'(outstanding), 64'(0));
      check("arst_write", 64'(req_fifo_write), 64'(0));
      check("arst_resp_valid", 64'(resp_valid), 64'(0));
      check("arst_data", 64'(req_fifo_data), 64'(0));
      repeat (2) next_cycle();
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

endmodule
